// File: rtl/apb_pkg.sv
// apb_pkg: types shared by the command-driven APB4 master and its FIFO.
// Holds the FSM state encoding and the command-word layout helpers.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // Command word, MSB first: {write, strb, wdata, addr}
    function automatic int cmd_width(input int addr_w, input int data_w);
        return 1 + data_w / 8 + data_w + addr_w;
    endfunction

    function automatic int wdata_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int strb_lsb(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// apb_cmd_fifo: synchronous show-ahead FIFO for queued APB commands.
// Ports: clk, rst, push/wr_data in, pop in, rd_data out, full/empty out.
module apb_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/apb_master_gen.sv
// apb_master_gen: queued APB4 master; cmd_* in, rsp_* out, APB P* bus.
// Ports: clk, rst, cmd valid/ready+fields, rsp valid/ready+fields, APB.
module apb_master_gen
    import apb_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   PADDR,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CMD_W  = cmd_width(ADDR_W, DATA_W);
    localparam int WD_LSB = wdata_lsb(ADDR_W);
    localparam int ST_LSB = strb_lsb(ADDR_W, DATA_W);
    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit TO_EN  = (TIMEOUT != 0);
    localparam logic [WCNT_W-1:0] WCNT_LAST =
        WCNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e        state_q;
    apb_state_e        state_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;

    logic [CMD_W-1:0]  fifo_rd;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    logic              f_write;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_wdata;
    logic [STRB_W-1:0] f_strb;

    logic              psel_d;
    logic              penable_d;
    logic              pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic [STRB_W-1:0] pstrb_d;
    logic              rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_d;
    logic              rsp_err_d;
    logic              rsp_timeout_d;
    logic              load;

    assign cmd_ready = !fifo_full;

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_valid),
        .wr_data ({cmd_write, cmd_strb, cmd_wdata, cmd_addr}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign f_write = fifo_rd[CMD_W-1];
    assign f_strb  = fifo_rd[ST_LSB +: STRB_W];
    assign f_wdata = fifo_rd[WD_LSB +: DATA_W];
    assign f_addr  = fifo_rd[ADDR_W-1:0];

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        psel_d        = PSEL;
        penable_d     = PENABLE;
        pwrite_d      = PWRITE;
        paddr_d       = PADDR;
        pwdata_d      = PWDATA;
        pstrb_d       = PSTRB;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;
        load          = 1'b0;
        fifo_pop      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                load = !fifo_empty;
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                wcnt_d    = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = PSLVERR;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!PWRITE && !PSLVERR) ? PRDATA : '0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end else if (TO_EN && wcnt_q == WCNT_LAST) begin
                    // wcnt_q counts completed ACCESS cycles minus one
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    state_d       = ST_RESP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pop straight into the SETUP phase; reads carry no data/strobes
        if (load) begin
            fifo_pop  = 1'b1;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = f_write;
            paddr_d   = f_addr;
            pwdata_d  = f_write ? f_wdata : '0;
            pstrb_d   = f_write ? f_strb : '0;
            state_d   = ST_SETUP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            PSEL        <= psel_d;
            PENABLE     <= penable_d;
            PWRITE      <= pwrite_d;
            PADDR       <= paddr_d;
            PWDATA      <= pwdata_d;
            PSTRB       <= pstrb_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_apb_master_gen.sv
// tb_apb_master_gen: randomized bench for apb_master_gen with a
// queue-based command/response model and a behavioural APB slave.
`timescale 1ns/1ps
module tb_apb_master_gen;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int STRB_W  = DATA_W / 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [STRB_W-1:0] cmd_strb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [STRB_W-1:0] PSTRB;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    always #5 clk = ~clk;

    apb_master_gen #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .CMD_DEPTH (DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    typedef struct {
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [STRB_W-1:0] s;
    } cmd_t;

    typedef struct {
        int                waits;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } plan_t;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              to;
    } rsp_t;

    cmd_t  cmd_q[$];
    cmd_t  pend_q[$];
    plan_t plan_q[$];
    rsp_t  exp_q[$];
    int    rises[$];

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    push_cyc = 0;
    int    setup_cyc = 0;
    int    acc_cyc = 0;
    int    last_rise = 0;
    int    rst_cyc = 0;
    int    n_to_rsp = 0;
    bit    rand_cmds = 1'b0;
    int    rdy_mode = 1;
    bit    cur_active = 1'b0;
    cmd_t  cur_cmd;
    plan_t cur_plan;
    int    acc_n = 0;
    logic  rsp_valid_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fields(input cmd_t c);
        logic [STRB_W-1:0] s;
        logic [DATA_W-1:0] d;
        s = c.w ? c.s : '0;
        d = c.w ? c.d : '0;
        return 64'({c.w, s, d, c.a});
    endfunction

    function automatic plan_t pick_plan();
        plan_t p;
        int    r;
        r = $urandom_range(0, 99);
        p.waits = (r < 8) ? TIMEOUT + $urandom_range(0, 4)
                          : $urandom_range(0, 3);
        p.err   = ($urandom_range(0, 4) == 0);
        p.rdata = $urandom;
        return p;
    endfunction

    function automatic cmd_t mk(input logic w, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d,
                                input logic [STRB_W-1:0] s);
        cmd_t c;
        c.w = w; c.a = a; c.d = d; c.s = s;
        return c;
    endfunction

    function automatic plan_t mkp(input int waits, input logic err,
                                  input logic [DATA_W-1:0] rdata);
        plan_t p;
        p.waits = waits; p.err = err; p.rdata = rdata;
        return p;
    endfunction

    function automatic bit idle();
        return cmd_q.size() == 0 && pend_q.size() == 0 &&
               exp_q.size() == 0 && !cur_active && !rsp_valid;
    endfunction

    task automatic drive_cmd(input cmd_t c);
        cmd_valid = 1'b1;
        cmd_write = c.w;
        cmd_addr  = c.a;
        cmd_wdata = c.d;
        cmd_strb  = c.s;
    endtask

    // One clock of bench activity, sampled and driven at the falling edge
    task automatic step();
        cmd_t c;
        rsp_t e;
        @(negedge clk);
        cyc++;

        if (PSEL && !PENABLE) begin
            check("setup_while_busy", 64'(cur_active), 0);
            cur_active = 1'b1;
            acc_n      = 0;
            setup_cyc  = cyc;
            cur_plan   = (plan_q.size() != 0) ? plan_q.pop_front() : pick_plan();
            if (pend_q.size() == 0) begin
                check("apb_unexpected_setup", 1, 0);
            end else begin
                cur_cmd = pend_q.pop_front();
                check("apb_setup_fields", {PWRITE, PSTRB, PWDATA, PADDR},
                      fields(cur_cmd));
            end
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end else if (PSEL && PENABLE) begin
            if (acc_n == 0) acc_cyc = cyc;
            check("apb_access_fields", {PWRITE, PSTRB, PWDATA, PADDR},
                  fields(cur_cmd));
            PREADY  = (acc_n == cur_plan.waits);
            PSLVERR = PREADY && cur_plan.err;
            PRDATA  = PREADY ? cur_plan.rdata : $urandom;
            acc_n++;
        end else begin
            if (cur_active) begin
                e.to    = (cur_plan.waits >= TIMEOUT);
                e.err   = e.to || cur_plan.err;
                e.rdata = (e.err || cur_cmd.w) ? '0 : cur_plan.rdata;
                check("access_cycles", 64'(acc_n),
                      64'(e.to ? TIMEOUT : cur_plan.waits + 1));
                exp_q.push_back(e);
                cur_active = 1'b0;
            end
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
        end

        check("cmd_ready", 64'(cmd_ready), 64'(pend_q.size() < DEPTH));

        case (rdy_mode)
            0:       rsp_ready = 1'b0;
            1:       rsp_ready = 1'b1;
            default: rsp_ready = ($urandom_range(0, 2) != 0);
        endcase
        if (rsp_valid && !rsp_valid_prev) begin
            rises.push_back(cyc);
            last_rise = cyc;
        end
        rsp_valid_prev = rsp_valid;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
                check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                if (e.to) n_to_rsp++;
            end
        end

        if (cmd_q.size() != 0) begin
            c = cmd_q[0];
            drive_cmd(c);
            if (cmd_ready) begin
                void'(cmd_q.pop_front());
                pend_q.push_back(c);
                push_cyc = cyc;
            end
        end else if (rand_cmds && $urandom_range(0, 2) == 0) begin
            c = mk(1'($urandom), ADDR_W'($urandom), $urandom, STRB_W'($urandom));
            drive_cmd(c);
            if (cmd_ready) begin
                pend_q.push_back(c);
                push_cyc = cyc;
            end
        end else begin
            cmd_valid = 1'b0;
        end
    endtask

    task automatic drain(input int budget);
        int b;
        b = budget;
        while (b > 0 && !idle()) begin
            step();
            b--;
        end
        check("drain_done", 64'(idle()), 1);
    endtask

    task automatic reset_checks(input string p);
        check({p, "_psel"}, 64'(PSEL), 0);
        check({p, "_penable"}, 64'(PENABLE), 0);
        check({p, "_pwrite"}, 64'(PWRITE), 0);
        check({p, "_paddr"}, 64'(PADDR), 0);
        check({p, "_pwdata"}, 64'(PWDATA), 0);
        check({p, "_pstrb"}, 64'(PSTRB), 0);
        check({p, "_rsp_valid"}, 64'(rsp_valid), 0);
        check({p, "_rsp_rdata"}, 64'(rsp_rdata), 0);
        check({p, "_rsp_err"}, 64'(rsp_err), 0);
        check({p, "_rsp_timeout"}, 64'(rsp_timeout), 0);
        check({p, "_cmd_ready"}, 64'(cmd_ready), 1);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        rst_cyc = cyc;
        cmd_q.delete();
        pend_q.delete();
        plan_q.delete();
        exp_q.delete();
        cur_active     = 1'b0;
        rsp_valid_prev = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nto;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b1;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        do_reset();
        reset_checks("rst");

        // single zero-wait read with latency stamps
        rdy_mode = 1;
        plan_q.push_back(mkp(0, 1'b0, 32'hDEADBEEF));
        cmd_q.push_back(mk(1'b0, 8'h04, 32'h1234_5678, 4'hF));
        drain(50);
        check("lat_psel", 64'(setup_cyc - push_cyc), 2);
        check("lat_penable", 64'(acc_cyc - push_cyc), 3);
        check("lat_rsp_valid", 64'(last_rise - push_cyc), 4);

        // write with two wait states, then slave error on a read
        plan_q.push_back(mkp(2, 1'b0, 32'h0));
        cmd_q.push_back(mk(1'b1, 8'h10, 32'hA5A5A5A5, 4'hF));
        plan_q.push_back(mkp(1, 1'b1, 32'hCAFEF00D));
        cmd_q.push_back(mk(1'b0, 8'h08, 32'h0, 4'h0));
        drain(60);

        // stuck PREADY, then a normal command behind it
        nto = n_to_rsp;
        plan_q.push_back(mkp(TIMEOUT + 10, 1'b0, 32'h0));
        cmd_q.push_back(mk(1'b0, 8'h30, 32'h0, 4'h0));
        plan_q.push_back(mkp(1, 1'b0, 32'h0));
        cmd_q.push_back(mk(1'b1, 8'h34, 32'h0BAD_F00D, 4'h3));
        drain(100);
        check("timeout_seen", 64'(n_to_rsp - nto), 1);

        // backpressure: five commands, responses held
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) begin
            plan_q.push_back(mkp(0, 1'b0, $urandom));
            cmd_q.push_back(mk(1'(i), ADDR_W'(8'h40 + 4 * i), $urandom, 4'hC));
        end
        for (int i = 0; i < 20 && cmd_q.size() != 0; i++) step();
        step();
        check("fifo_full_ready", 64'(cmd_ready), 0);
        for (int i = 0; i < 4; i++) step();
        check("rsp_held", 64'(rsp_valid), 1);
        rises.delete();
        rdy_mode = 1;
        drain(100);
        check("b2b_rises", 64'(rises.size()), 4);
        for (int i = 1; i < rises.size(); i++) begin
            check("b2b_spacing", 64'(rises[i] - rises[i-1]), 3);
        end

        // reset in the middle of a waited transfer
        plan_q.push_back(mkp(8, 1'b0, 32'h0));
        cmd_q.push_back(mk(1'b0, 8'h20, 32'h0, 4'h0));
        for (int i = 0; i < 30 && !(cur_active && acc_n >= 3); i++) step();
        check("rst_reach_access", 64'(cur_active && acc_n >= 3), 1);
        do_reset();
        reset_checks("midrst");
        plan_q.push_back(mkp(0, 1'b0, 32'h0));
        cmd_q.push_back(mk(1'b1, 8'h24, 32'h7777_0000, 4'h5));
        drain(50);
        check("push_after_rst", 64'(push_cyc - rst_cyc), 1);

        // randomized traffic and backpressure
        rand_cmds = 1'b1;
        rdy_mode  = 2;
        for (int i = 0; i < 800; i++) step();
        rand_cmds = 1'b0;
        rdy_mode  = 1;
        cmd_valid = 1'b0;
        drain(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
